// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer: FSM states, LFSR constants
// and a BCD helper.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRun,
        StDone,
        StEarly,
        StTimeout
    } rt_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // All-9s BCD pattern in the low 4*digits bits (max 16 digits).
    function automatic logic [63:0] bcd_all_nines(input int unsigned digits);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < digits) r[4*i +: 4] = 4'h9;
        end
        return r;
    endfunction

endpackage

// File: rtl/reaction_timer_rand_bcd_up_counter.sv
// Multi-digit BCD up counter with synchronous clear; saturates at all-9s.
module bcd_up_counter
    import reaction_timer_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   q,
    output logic                  max
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [63:0] NINES_W = bcd_all_nines(DIGITS);
    localparam logic [W-1:0] NINES = NINES_W[W-1:0];

    logic [W-1:0] q_q, q_d;
    logic         carry;

    always_comb begin
        q_d   = q_q;
        carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (q_q[4*i +: 4] == 4'd9) begin
                    q_d[4*i +: 4] = 4'd0;
                end else begin
                    q_d[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (inc && !max) begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign max = (q_q == NINES);

endmodule

// File: rtl/reaction_timer_rand.sv
// Reaction-time tester: random delay, stimulus lamp, BCD ms count, early/timeout
// detection and best-time register.
module reaction_timer_rand
    import reaction_timer_pkg::*;
#(
    parameter int unsigned CLK_PER_MS      = 50000,
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DELAY_MIN_MS    = 2000,
    parameter int unsigned DELAY_SPAN_LOG2 = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    output logic [4*DIGITS-1:0] times,
    output logic [4*DIGITS-1:0] best,
    output logic                led,
    output logic                done,
    output logic                early,
    output logic                timeout
);

    localparam int unsigned TW    = 4 * DIGITS;
    localparam int unsigned DIV_W = $clog2(CLK_PER_MS);
    localparam int unsigned DLY_W = $clog2(DELAY_MIN_MS + (1 << DELAY_SPAN_LOG2)) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_MS - 1);
    localparam logic [DLY_W-1:0] DLY_BASE = DLY_W'(DELAY_MIN_MS);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [63:0]      NINES_W  = bcd_all_nines(DIGITS);
    localparam logic [TW-1:0]    NINES    = NINES_W[TW-1:0];

    rt_state_t         state_q;
    logic [15:0]       lfsr_q;
    logic [DIV_W-1:0]  div_q;
    logic [DLY_W-1:0]  delay_q;
    logic [TW-1:0]     best_q;
    logic              led_q, done_q, early_q, timeout_q;

    logic              ms_tick;
    logic              lfsr_fb;
    logic              cnt_clr, cnt_inc, cnt_max;
    logic [TW-1:0]     cnt_q;

    assign ms_tick = (div_q == DIV_LAST);
    assign lfsr_fb = ^(lfsr_q & LFSR_TAPS);

    // Counter controls follow the same priority as the FSM below.
    always_comb begin
        cnt_clr = clear || (state_q == StIdle && start);
        cnt_inc = !clear && !stop && ms_tick && (state_q == StRun);
    end

    bcd_up_counter #(
        .DIGITS (DIGITS)
    ) u_count (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .q     (cnt_q),
        .max   (cnt_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            lfsr_q    <= LFSR_SEED;
            div_q     <= '0;
            delay_q   <= '0;
            best_q    <= NINES;
            led_q     <= 1'b0;
            done_q    <= 1'b0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
            div_q  <= ms_tick ? '0 : div_q + 1'b1;
            if (clear) begin
                state_q   <= StIdle;
                led_q     <= 1'b0;
                done_q    <= 1'b0;
                early_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q <= StWait;
                            delay_q <= DLY_BASE + DLY_W'(lfsr_q[DELAY_SPAN_LOG2-1:0]);
                            div_q   <= '0;
                        end
                    end
                    StWait: begin
                        if (stop) begin
                            state_q <= StEarly;
                            early_q <= 1'b1;
                        end else if (ms_tick) begin
                            if (delay_q == DLY_ONE) begin
                                state_q <= StRun;
                                led_q   <= 1'b1;
                                div_q   <= '0;
                            end else begin
                                delay_q <= delay_q - 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (stop) begin
                            state_q <= StDone;
                            led_q   <= 1'b0;
                            done_q  <= 1'b1;
                            if (cnt_q < best_q) best_q <= cnt_q;
                        end else if (ms_tick && cnt_max) begin
                            state_q   <= StTimeout;
                            led_q     <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // EARLY displays all-9s without disturbing the counter.
    assign times   = early_q ? NINES : cnt_q;
    assign best    = best_q;
    assign led     = led_q;
    assign done    = done_q;
    assign early   = early_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_reaction_timer_rand.sv
// Scoreboard bench for reaction_timer_rand with a small, fast parameter set.
module tb_reaction_timer_rand;

    localparam int unsigned CLK_PER_MS = 4;
    localparam int unsigned DIGITS     = 2;
    localparam int unsigned DMIN       = 2;
    localparam int unsigned SPAN       = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] times, best;
    logic       led, done, early, timeout;

    always #5 clk = ~clk;

    reaction_timer_rand #(
        .CLK_PER_MS      (CLK_PER_MS),
        .DIGITS          (DIGITS),
        .DELAY_MIN_MS    (DMIN),
        .DELAY_SPAN_LOG2 (SPAN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .times   (times),
        .best    (best),
        .led     (led),
        .done    (done),
        .early   (early),
        .timeout (timeout)
    );

    typedef struct {
        string      tag;
        logic [7:0] times;
        logic [7:0] best;
        logic       done;
        logic       early;
        logic       timeout;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_lfsr;
    logic [7:0]  m_best;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting toward the MSB.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic score();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_times"}, times, e.times);
        check({e.tag, "_best"}, best, e.best);
        check({e.tag, "_done"}, done, e.done);
        check({e.tag, "_early"}, early, e.early);
        check({e.tag, "_timeout"}, timeout, e.timeout);
    endtask

    task automatic wait_led(output int cycles);
        cycles = 0;
        while (!led && cycles < 100) begin
            cyc();
            cycles++;
        end
        check("led_rise", led, 1);
    endtask

    // Trial whose stop is sampled n edges after the edge that raised led.
    task automatic trial(input string tag, input int n);
        int   exp_wait, w;
        exp_t e;
        exp_wait = 4 * (DMIN + m_lfsr[1:0]);
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_led(w);
        check({tag, "_wait"}, w, exp_wait);
        repeat (n - 1) cyc();
        check({tag, "_led_run"}, led, 1);
        e.tag = tag;
        e.times = to_bcd((n - 1) / 4);
        if (e.times < m_best) m_best = e.times;
        e.best = m_best;
        e.done = 1'b1;
        e.early = 1'b0;
        e.timeout = 1'b0;
        sb.push_back(e);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        score();
        check({tag, "_led_off"}, led, 0);
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check({tag, "_times"}, times, 8'h00);
        check({tag, "_best"}, best, m_best);
        check({tag, "_flags"}, {led, done, early, timeout}, 4'b0000);
    endtask

    initial begin
        exp_t e;
        int   w, k;
        logic saw_led;

        repeat (2) cyc();
        reset = 1'b0;
        m_best = 8'h99;
        check("rst_times", times, 8'h00);
        check("rst_best", best, 8'h99);
        check("rst_flags", {led, done, early, timeout}, 4'b0000);

        trial("normal", 37);
        do_clear("clr_normal");
        trial("slow", 61);
        do_clear("clr_slow");
        trial("fast", 17);
        do_clear("clr_fast");
        trial("collide", 8);
        do_clear("clr_collide");

        // Early press: stop three cycles after start.
        start = 1'b1;
        cyc();
        start = 1'b0;
        saw_led = 1'b0;
        repeat (2) begin
            cyc();
            saw_led |= led;
        end
        e.tag = "early";
        e.times = 8'h99;
        e.best = m_best;
        e.done = 1'b0;
        e.early = 1'b1;
        e.timeout = 1'b0;
        sb.push_back(e);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        score();
        check("early_led_never", saw_led | led, 0);
        start = 1'b1;
        repeat (3) cyc();
        start = 1'b0;
        check("early_hold", {early, times}, {1'b1, 8'h99});
        do_clear("clr_early");

        // Timeout: no stop at all.
        e.tag = "timeout";
        e.times = 8'h99;
        e.best = m_best;
        e.done = 1'b0;
        e.early = 1'b0;
        e.timeout = 1'b1;
        sb.push_back(e);
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_led(w);
        k = 0;
        while (!timeout && k < 600) begin
            cyc();
            k++;
        end
        score();
        check("timeout_cycles", k, 400);
        check("timeout_led", led, 0);
        stop = 1'b1;
        repeat (6) cyc();
        stop = 1'b0;
        check("timeout_nowrap", {timeout, times}, {1'b1, 8'h99});
        do_clear("clr_timeout");

        // Reset mid-trial restores best as well.
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_led(w);
        repeat (5) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m_best = 8'h99;
        check("midrst_best", best, 8'h99);
        check("midrst_times", times, 8'h00);
        check("midrst_flags", {led, done, early, timeout}, 4'b0000);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
